// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational for IF; training happens on EXE-resolved control flow.
module branch_target_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_if,
    output logic        jump_if,
    output logic [63:0] pc_target_if,
    input  logic        upd_valid,
    input  logic        upd_is_cf,
    input  logic        upd_taken,
    input  logic [63:0] upd_pc,
    input  logic [63:0] upd_target,
    input  logic        mispredict,
    output logic [31:0] mispredict_cnt
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;
    localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [63:0]         target_q [ENTRIES];
    logic [63:0]         target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];
    logic [31:0]         cnt_q;
    logic [31:0]         cnt_d;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  lk_hit;
    logic                  up_hit;
    logic                  up_en;
    logic [ENTRIES-1:0]    entry_we;
    logic                  unused_pc_bits;

    assign lk_idx = pc_if[INDEX_BITS+1:2];
    assign lk_tag = pc_if[TAG_MSB:TAG_LSB];
    assign up_idx = upd_pc[INDEX_BITS+1:2];
    assign up_tag = upd_pc[TAG_MSB:TAG_LSB];
    assign up_en  = upd_valid && upd_is_cf;

    // Bits outside the index/tag fields never participate in matching.
    assign unused_pc_bits = ^{pc_if[63:TAG_MSB+1], pc_if[1:0],
                              upd_pc[63:TAG_MSB+1], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        jump_if      = lk_hit && ctr_q[lk_idx][1];
        pc_target_if = jump_if ? target_q[lk_idx] : 64'd0;
        up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_we
            assign entry_we[gi] = up_en && (up_idx == INDEX_BITS'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
            if (entry_we[i]) begin
                if (up_hit) begin
                    if (upd_taken) begin
                        if (ctr_q[i] != 2'b11) ctr_d[i] = ctr_q[i] + 2'd1;
                        target_d[i] = upd_target;
                    end else if (ctr_q[i] != 2'b00) begin
                        ctr_d[i] = ctr_q[i] - 2'd1;
                    end
                end else if (upd_taken) begin
                    // Miss-taken replaces whatever aliased entry lived here.
                    valid_d[i]  = 1'b1;
                    tag_d[i]    = up_tag;
                    target_d[i] = upd_target;
                    ctr_d[i]    = 2'b10;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && upd_valid && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus randomized traffic
// checked against a per-entry behavioural model of the predictor rules.
module tb_branch_target_predictor;
    localparam int IB = 4;
    localparam int TB = 10;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_if;
    logic        jump_if;
    logic [63:0] pc_target_if;
    logic        upd_valid;
    logic        upd_is_cf;
    logic        upd_taken;
    logic [63:0] upd_pc;
    logic [63:0] upd_target;
    logic        mispredict;
    logic [31:0] mispredict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [63:0] m_tgt   [N];
    int          m_ctr   [N];
    longint unsigned m_cnt;

    branch_target_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .jump_if(jump_if),
        .pc_target_if(pc_target_if), .upd_valid(upd_valid), .upd_is_cf(upd_is_cf),
        .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_target(upd_target),
        .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) & 64'(N - 1));
    endfunction

    function automatic int unsigned tag_of(input logic [63:0] pc);
        return int'((pc >> (IB + 2)) & 64'((1 << TB) - 1));
    endfunction

    function automatic void model_lookup(input logic [63:0] pc, output logic j, output logic [63:0] t);
        int i;
        i = idx_of(pc);
        j = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        t = j ? m_tgt[i] : 64'd0;
    endfunction

    // Advance one clock edge and apply the predictor rules to the model.
    task automatic clock_edge();
        int i;
        bit hit;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 64'd0; m_ctr[k] = 1;
            end
            m_cnt = 0;
        end else begin
            if (upd_valid && upd_is_cf) begin
                i = idx_of(upd_pc);
                hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
                if (hit) begin
                    if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
                end
            end
            if (mispredict && upd_valid && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; upd_valid = 1'b0; upd_is_cf = 1'b0; upd_taken = 1'b0;
        upd_pc = 64'd0; upd_target = 64'd0; mispredict = 1'b0;
    endtask

    task automatic upd(input logic [63:0] pc, input logic taken, input logic [63:0] tgt);
        upd_valid = 1'b1; upd_is_cf = 1'b1; upd_taken = taken; upd_pc = pc; upd_target = tgt;
        clock_edge();
        set_idle();
        $display("upd pc=%h taken=%b target=%h", pc, taken, tgt);
    endtask

    task automatic expect_pred(input string name, input logic [63:0] pc, input logic ej, input logic [63:0] et);
        pc_if = pc;
        #1;
        n_cmp++;
        if (jump_if !== ej) begin
            n_bad++; $display("FAIL %s_jump pc=%h got %b want %b", name, pc, jump_if, ej);
        end
        n_cmp++;
        if (pc_target_if !== et) begin
            n_bad++; $display("FAIL %s_target pc=%h got %h want %h", name, pc, pc_target_if, et);
        end
        $display("look %s pc=%h jump=%b target=%h", name, pc, jump_if, pc_target_if);
    endtask

    task automatic test_reset();
        rst = 1'b1; clock_edge(); clock_edge(); set_idle();
        for (int k = 0; k < N; k++) begin
            upd_valid = 1'b1; mispredict = 1'b1;
            upd(64'(k * 4), 1'b1, 64'h1000 + 64'(k));
        end
        rst = 1'b1; clock_edge(); set_idle();
        for (int k = 0; k < N; k++) expect_pred("reset", 64'(k * 4), 1'b0, 64'd0);
        n_cmp++;
        if (mispredict_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt);
        end
    endtask

    task automatic test_allocate();
        upd(64'h100, 1'b1, 64'h200);
        expect_pred("alloc_hit", 64'h100, 1'b1, 64'h200);
        expect_pred("alloc_other", 64'h104, 1'b0, 64'd0);
    endtask

    task automatic test_saturation();
        upd(64'h100, 1'b1, 64'h200);
        upd(64'h100, 1'b1, 64'h200);
        expect_pred("sat_top", 64'h100, 1'b1, 64'h200);
        upd(64'h100, 1'b0, 64'h0);
        expect_pred("sat_nt1", 64'h100, 1'b1, 64'h200);
        upd(64'h100, 1'b0, 64'h0);
        expect_pred("sat_nt2", 64'h100, 1'b0, 64'd0);
        upd(64'h100, 1'b0, 64'h0);
        upd(64'h100, 1'b0, 64'h0);
        expect_pred("sat_floor", 64'h100, 1'b0, 64'd0);
        upd(64'h100, 1'b1, 64'h240);
        expect_pred("sat_up1", 64'h100, 1'b0, 64'd0);
        upd(64'h100, 1'b1, 64'h240);
        expect_pred("sat_up2", 64'h100, 1'b1, 64'h240);
    endtask

    task automatic test_alias();
        upd(64'h140, 1'b0, 64'h0);
        expect_pred("alias_keep", 64'h100, 1'b1, 64'h240);
        upd(64'h140, 1'b1, 64'h300);
        expect_pred("alias_new", 64'h140, 1'b1, 64'h300);
        expect_pred("alias_old", 64'h100, 1'b0, 64'd0);
    endtask

    task automatic test_same_cycle();
        upd_valid = 1'b1; upd_is_cf = 1'b1; upd_taken = 1'b1;
        upd_pc = 64'h180; upd_target = 64'h400;
        expect_pred("same_pre", 64'h180, 1'b0, 64'd0);
        clock_edge();
        set_idle();
        expect_pred("same_post", 64'h180, 1'b1, 64'h400);
    endtask

    task automatic test_counter();
        for (int k = 0; k < 5; k++) begin
            upd_valid = 1'b1; mispredict = 1'b1; clock_edge();
        end
        set_idle();
        n_cmp++;
        if (mispredict_cnt !== 32'd5) begin
            n_bad++; $display("FAIL cnt_five got %0d want 5", mispredict_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            mispredict = 1'b1; clock_edge();
        end
        set_idle();
        n_cmp++;
        if (mispredict_cnt !== 32'd5) begin
            n_bad++; $display("FAIL cnt_novalid got %0d want 5", mispredict_cnt);
        end
        $display("cnt mispredict_cnt=%0d", mispredict_cnt);
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; upd_valid = 1'b1; upd_is_cf = 1'b1; upd_taken = 1'b1;
        upd_pc = 64'h1C0; upd_target = 64'h500; mispredict = 1'b1;
        clock_edge();
        set_idle();
        expect_pred("rstpri_new", 64'h1C0, 1'b0, 64'd0);
        expect_pred("rstpri_old", 64'h180, 1'b0, 64'd0);
        n_cmp++;
        if (mispredict_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rstpri_cnt got %0d want 0", mispredict_cnt);
        end
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        pc = {$urandom, $urandom};
        pc[TB+IB+1:IB+2] = TB'($urandom_range(0, 2));
        pc[IB+1:2] = IB'($urandom_range(0, 3));
        return pc;
    endfunction

    task automatic test_random();
        logic ej;
        logic [63:0] et;
        for (int t = 0; t < 300; t++) begin
            rst        = ($urandom_range(0, 63) == 0);
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_is_cf  = ($urandom_range(0, 3) != 0);
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_pc     = rand_pc();
            upd_target = {$urandom, $urandom};
            mispredict = ($urandom_range(0, 3) == 0);
            pc_if      = rand_pc();
            #1;
            model_lookup(pc_if, ej, et);
            n_cmp++;
            if (jump_if !== ej) begin
                n_bad++; $display("FAIL rand_jump t=%0d pc=%h got %b want %b", t, pc_if, jump_if, ej);
            end
            n_cmp++;
            if (pc_target_if !== et) begin
                n_bad++; $display("FAIL rand_target t=%0d pc=%h got %h want %h", t, pc_if, pc_target_if, et);
            end
            n_cmp++;
            if (64'(mispredict_cnt) !== m_cnt) begin
                n_bad++; $display("FAIL rand_cnt t=%0d got %0d want %0d", t, mispredict_cnt, m_cnt);
            end
            $display("txn %0d pc_if=%h jump=%b upd=%b%b%b pc=%h rst=%b cnt=%0d", t, pc_if, jump_if,
                     upd_valid, upd_is_cf, upd_taken, upd_pc, rst, mispredict_cnt);
            clock_edge();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        pc_if = 64'd0;
        #2;
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_counter();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters.
- Drives the IF-stage prediction (`jump_if`, `pc_target_if`) consumed by the PC select mux.
- Trains from resolved control-flow outcomes in EXE, which effectively schedules the next-PC source each cycle.
- Also keeps a mispredict count for performance monitoring.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries).
- TAG_BITS, 10, tag width taken from PC bits above the index.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- pc_if  input  64  PC of the instruction in IF
- jump_if  output  1  predict taken for pc_if
- pc_target_if  output  64  predicted target for pc_if
- upd_valid  input  1  EXE holds a valid, non-stalled instruction this cycle
- upd_is_cf  input  1  EXE instruction is a branch or jump (npc_sel)
- upd_taken  input  1  resolved direction (jump_exe)
- upd_pc  input  64  PC of the EXE instruction
- upd_target  input  64  resolved target (alu_res)
- mispredict  input  1  error_prediction from the PC select mux
- mispredict_cnt  output  32  number of mispredicted cycles counted

Behaviour:
- Field extraction:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
  - pc[1:0] is ignored.
- Entry contents: valid (1), tag (TAG_BITS), target (64), ctr (2).
- Lookup is combinational from the stored table, with zero-cycle latency:
  - hit = valid[idx] && tag[idx] == tag(pc_if)
  - jump_if = hit && ctr[idx][1]
  - pc_target_if = target[idx] when jump_if, else 0
- Update is applied at the rising edge only when upd_valid && upd_is_cf:
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid even at ctr=0.
  - Miss, taken: allocate and overwrite any previous occupant. valid=1, tag=tag(upd_pc), target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- upd_valid=0, or upd_is_cf=0: table unchanged.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents; the new contents are visible from the next cycle.
- mispredict_cnt: +1 on each clock edge where mispredict=1 && upd_valid=1. It saturates at 0xFFFF_FFFF and does not wrap.
- Reset (synchronous, takes priority over the same-cycle update):
  - All valid=0, all ctr=2'b01, targets and tags=0, mispredict_cnt=0.
  - Consequence: jump_if=0 and pc_target_if=0 starting the cycle after the reset edge, for any pc_if.
  - Reset mid-training discards all learned state; no partial update is committed on the reset edge.
- Storage uses flops (no SRAM) so that the lookup stays combinational.

Test Plan:
- Reset: assert rst 1 cycle, then sweep pc_if over 0x0..0x3C → jump_if=0 and pc_target_if=0 for all; mispredict_cnt=0.
- Allocate: update pc=0x100, taken, target=0x200 → next cycle pc_if=0x100 gives jump_if=1, pc_target_if=0x200. pc_if=0x104 gives jump_if=0.
- Saturation: after allocate (ctr=10), apply 2 taken updates on 0x100 → ctr=11. Then apply 3 not-taken updates → ctr 10, 01, 00. jump_if stays 1 after the first not-taken and drops to 0 after the second. A further not-taken leaves ctr=00, and one taken update returns ctr to 01 with jump_if still 0.
- Alias/replace:
  - Setup: 0x100 allocated; a miss not-taken update at 0x140 (same index 0, different tag) leaves 0x100 still predicted.
  - Stimulus: a taken update at 0x140 with target 0x300.
  - Response: pc_if=0x140 hits (0x300); pc_if=0x100 misses, jump_if=0.
- Same-cycle: drive pc_if=0x180 while allocating 0x180 taken in the same cycle → jump_if=0 that cycle, 1 the following cycle.
- Counter and reset priority:
  - Assert mispredict && upd_valid for 5 cycles → mispredict_cnt=5. Mispredict with upd_valid=0 does not count.
  - Assert rst together with a taken update → table stays empty and mispredict_cnt=0.
